fixed_order_arbiter_requester: RTL and testbench

Requester-side front end for the 4-channel fixed-order arbiter with pending requests. It accepts payloads from four upstream clients over valid/ready, buffers them per channel, and issues exactly one single-cycle `req` pulse per buffered payload. It then waits for the matching `grant` pulse and forwards the granted payload onto a shared output bus tagged with its channel id. It sits between the clients and the arbiter. Because the arbiter latches each request into its pending bit, `req` must be a pulse and never a level.

---
 rtl/fixed_order_arbiter_pkg.sv | 12 +
 rtl/fixed_order_arbiter_req_channel.sv | 124 ++++++++++++
 rtl/fixed_order_arbiter_requester.sv | 109 ++++++++++
 tb/tb_fixed_order_arbiter_requester.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_order_arbiter_pkg.sv
// Shared constants and types for the fixed-order arbiter requester front end.
package fixed_order_arbiter_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned ID_W   = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } req_state_t;

endpackage

// File: rtl/fixed_order_arbiter_req_channel.sv
// One requester channel: payload FIFO, IDLE/WAIT request FSM, timeout counter,
// single-cycle req pulse and eligible-grant detection.
module fixed_order_arbiter_req_channel
    import fixed_order_arbiter_pkg::*;
#(
    parameter int unsigned DW      = 8,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [DW-1:0] i_in_data,
    input  logic          i_grant,
    input  logic          i_pop,
    output logic          o_req,
    output logic          o_eligible,
    output logic [DW-1:0] o_head,
    output logic          o_timeout
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_d;
    logic          w_push;

    req_state_t    r_state;
    req_state_t    w_state_d;
    logic          r_req;
    logic          w_req_d;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_d;
    logic          r_timeout;
    logic          w_timeout_d;

    // Ready depends on the registered count, so a same-cycle pop frees a slot one cycle later.
    assign o_in_ready = ~rst & (r_count != CW'(DEPTH));
    assign w_push     = i_in_valid & o_in_ready;
    assign o_head     = r_mem[r_rd_ptr];
    assign o_req      = r_req;
    assign o_timeout  = r_timeout;
    assign o_eligible = (r_state == WAIT) & ~r_req & i_grant;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_in_data;
        end
    end

    always_comb begin
        w_count_d = r_count;
        unique case ({w_push, i_pop})
            2'b10:   w_count_d = r_count + 1'b1;
            2'b01:   w_count_d = r_count - 1'b1;
            default: w_count_d = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_req_d     = 1'b0;
        w_timer_d   = r_timer;
        w_timeout_d = r_timeout;
        unique case (r_state)
            IDLE: begin
                if (r_count != '0) begin
                    w_state_d = WAIT;
                    w_req_d   = 1'b1;
                    w_timer_d = '0;
                end
            end
            WAIT: begin
                if (r_timer != TW'(TIMEOUT)) begin
                    w_timer_d = r_timer + 1'b1;
                end
                if (w_timer_d == TW'(TIMEOUT)) begin
                    w_timeout_d = 1'b1;
                end
                if (i_pop) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_req     <= 1'b0;
            r_timer   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_req     <= w_req_d;
            r_timer   <= w_timer_d;
            r_timeout <= w_timeout_d;
        end
    end

endmodule

// File: rtl/fixed_order_arbiter_requester.sv
// Requester front end: four buffered channels, lowest-index grant servicing,
// registered output bus and sticky protocol error flags.
module fixed_order_arbiter_requester
    import fixed_order_arbiter_pkg::*;
#(
    parameter int unsigned DW      = 8,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    in_valid,
    output logic [NUM_CH-1:0]    in_ready,
    input  logic [NUM_CH*DW-1:0] in_data,
    output logic [NUM_CH-1:0]    req,
    input  logic [NUM_CH-1:0]    grant,
    output logic                 out_valid,
    output logic [ID_W-1:0]      out_id,
    output logic [DW-1:0]        out_data,
    output logic [NUM_CH-1:0]    err_timeout,
    output logic                 err_spurious,
    output logic                 err_multi
);

    logic [NUM_CH-1:0] w_eligible;
    logic [NUM_CH-1:0] w_sel;
    logic [DW-1:0]     w_head [NUM_CH];
    logic              w_sel_valid;
    logic [ID_W-1:0]   w_sel_id;
    logic [DW-1:0]     w_sel_data;
    logic              w_spurious;
    logic              w_multi;

    logic              r_out_valid;
    logic [ID_W-1:0]   r_out_id;
    logic [DW-1:0]     r_out_data;
    logic              r_err_spurious;
    logic              r_err_multi;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        fixed_order_arbiter_req_channel #(
            .DW      (DW),
            .DEPTH   (DEPTH),
            .TIMEOUT (TIMEOUT)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .i_in_valid (in_valid[g]),
            .o_in_ready (in_ready[g]),
            .i_in_data  (in_data[g*DW +: DW]),
            .i_grant    (grant[g]),
            .i_pop      (w_sel[g]),
            .o_req      (req[g]),
            .o_eligible (w_eligible[g]),
            .o_head     (w_head[g]),
            .o_timeout  (err_timeout[g])
        );
    end

    // Descending scan so the lowest eligible index is the one left selected.
    always_comb begin
        w_sel       = '0;
        w_sel_valid = 1'b0;
        w_sel_id    = '0;
        w_sel_data  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_sel       = '0;
                w_sel[i]    = 1'b1;
                w_sel_valid = 1'b1;
                w_sel_id    = ID_W'(i);
                w_sel_data  = w_head[i];
            end
        end
    end

    // Any grant bit that did not service a channel is spurious.
    assign w_spurious = |(grant & ~w_sel);
    assign w_multi    = (grant & (grant - 1'b1)) != '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid    <= 1'b0;
            r_out_id       <= '0;
            r_out_data     <= '0;
            r_err_spurious <= 1'b0;
            r_err_multi    <= 1'b0;
        end else begin
            r_out_valid <= w_sel_valid;
            if (w_sel_valid) begin
                r_out_id   <= w_sel_id;
                r_out_data <= w_sel_data;
            end
            if (w_spurious) begin
                r_err_spurious <= 1'b1;
            end
            if (w_multi) begin
                r_err_multi <= 1'b1;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_id       = r_out_id;
    assign out_data     = r_out_data;
    assign err_spurious = r_err_spurious;
    assign err_multi    = r_err_multi;

endmodule

// File: tb/tb_fixed_order_arbiter_requester.sv
// Bench for fixed_order_arbiter_requester: arbiter model, output scoreboard,
// table-driven single-push vectors and hand-written corner-case sequences.
module tb_fixed_order_arbiter_requester;
    import fixed_order_arbiter_pkg::*;

    localparam int unsigned DW      = 8;
    localparam int unsigned DEPTH   = 2;
    localparam int unsigned TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        in_valid;
    logic [3:0]        in_ready;
    logic [4*DW-1:0]   in_data;
    logic [3:0]        req;
    logic [3:0]        grant;
    logic              out_valid;
    logic [1:0]        out_id;
    logic [DW-1:0]     out_data;
    logic [3:0]        err_timeout;
    logic              err_spurious;
    logic              err_multi;

    always #5 clk = ~clk;

    fixed_order_arbiter_requester #(
        .DW      (DW),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .req          (req),
        .grant        (grant),
        .out_valid    (out_valid),
        .out_id       (out_id),
        .out_data     (out_data),
        .err_timeout  (err_timeout),
        .err_spurious (err_spurious),
        .err_multi    (err_multi)
    );

    // Fixed-order arbiter model: latches req pulses as pending, grants lowest pending one-hot.
    logic       enable;
    logic       manual;
    logic [3:0] man_grant;
    logic [3:0] arb_grant;
    logic [3:0] pending;
    logic [3:0] pend_eff;
    logic [3:0] pend_low;

    assign pend_eff = pending | req;
    assign pend_low = pend_eff & (~pend_eff + 4'd1);
    assign grant    = manual ? man_grant : arb_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_grant <= '0;
            pending   <= '0;
        end else if (enable && pend_eff != '0) begin
            arb_grant <= pend_low;
            pending   <= pend_eff & ~pend_low;
        end else begin
            arb_grant <= '0;
            pending   <= pend_eff;
        end
    end

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        int            ch;
        logic [DW-1:0] data;
        logic [3:0]    exp_req;
        logic [1:0]    exp_id;
    } vec_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_cmp;
    int         n_err;
    int         out_cnt;
    int         req_cnt [4];
    logic [3:0] prev_req;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int ch, input logic [DW-1:0] d);
        exp_t e;
        e.id   = 2'(ch);
        e.data = d;
        return e;
    endfunction

    // Output scoreboard and req pulse-width monitor.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (req[i]) req_cnt[i]++;
                if (prev_req[i]) check("req_single_cycle", 32'(req[i]), 32'(0));
            end
            prev_req = req;
            if (out_valid) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    check("out_valid_unexpected", 32'(out_valid), 32'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_id", 32'(out_id), 32'(mon_e.id));
                    check("out_data", 32'(out_data), 32'(mon_e.data));
                end
            end
        end else begin
            prev_req = '0;
        end
    end

    task automatic drive_push(input logic [3:0] mask, input logic [4*DW-1:0] data);
        @(negedge clk);
        in_valid = mask;
        in_data  = data;
        @(posedge clk);
        #1;
        in_valid = '0;
    endtask

    task automatic wait_outs(input int target, input string name);
        int b = 0;
        while (out_cnt < target && b < 200) begin
            @(negedge clk);
            b++;
        end
        check(name, 32'(out_cnt), 32'(target));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_req", 32'(req), 32'(0));
        check("rst_out", 32'({out_valid, out_id, out_data}), 32'(0));
        check("rst_errs", 32'({err_timeout, err_spurious, err_multi}), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'hF);
    endtask

    vec_t vecs [4];
    int   ocnt0;
    int   base1;
    int   base2;
    logic saw_full;

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        enable    = 1'b1;
        manual    = 1'b0;
        man_grant = '0;
        prev_req  = '0;
        vecs[0] = '{ch: 2, data: 8'hA5, exp_req: 4'b0100, exp_id: 2'd2};
        vecs[1] = '{ch: 0, data: 8'h3C, exp_req: 4'b0001, exp_id: 2'd0};
        vecs[2] = '{ch: 1, data: 8'hFF, exp_req: 4'b0010, exp_id: 2'd1};
        vecs[3] = '{ch: 3, data: 8'h00, exp_req: 4'b1000, exp_id: 2'd3};

        do_reset();

        // Uncontended single pushes: req one cycle after push, out_valid three cycles after.
        for (int v = 0; v < 4; v++) begin
            exp_q.push_back(mk(vecs[v].ch, vecs[v].data));
            drive_push(4'(1 << vecs[v].ch), {4{vecs[v].data}});
            @(negedge clk);
            check("req_k0", 32'(req), 32'(0));
            @(negedge clk);
            check("req_k1", 32'(req), 32'(vecs[v].exp_req));
            @(negedge clk);
            check("req_k2", 32'(req), 32'(0));
            check("out_valid_k2", 32'(out_valid), 32'(0));
            @(negedge clk);
            check("out_valid_k3", 32'(out_valid), 32'(1));
            repeat (3) @(negedge clk);
        end

        // All four channels in one cycle: outputs in index order.
        ocnt0 = out_cnt;
        for (int c = 0; c < 4; c++) exp_q.push_back(mk(c, 8'(8'h10 + c)));
        drive_push(4'b1111, {8'h13, 8'h12, 8'h11, 8'h10});
        @(negedge clk);
        @(negedge clk);
        check("req_all", 32'(req), 32'hF);
        wait_outs(ocnt0 + 4, "four_outputs");
        repeat (3) @(negedge clk);
        check("four_no_extra", 32'(out_cnt), 32'(ocnt0 + 4));
        check("four_no_spurious", 32'({err_spurious, err_multi}), 32'(0));

        // Three back-to-back pushes into a depth-2 FIFO.
        ocnt0    = out_cnt;
        base1    = req_cnt[1];
        saw_full = 1'b0;
        for (int k = 0; k < 3; k++) begin
            int b = 0;
            exp_q.push_back(mk(1, 8'(8'h20 + k)));
            @(negedge clk);
            in_valid = 4'b0010;
            in_data  = {4{8'(8'h20 + k)}};
            while (in_ready[1] !== 1'b1 && b < 50) begin
                saw_full = 1'b1;
                @(negedge clk);
                b++;
            end
            check("ch1_push_ready", 32'(in_ready[1]), 32'(1));
            @(posedge clk);
            #1;
            in_valid = '0;
        end
        wait_outs(ocnt0 + 3, "fifo_three_outputs");
        repeat (4) @(negedge clk);
        check("fifo_saw_full", 32'(saw_full), 32'(1));
        check("fifo_req1_pulses", 32'(req_cnt[1] - base1), 32'(3));

        // Arbiter disabled long enough for ch3 to time out.
        check("pre_timeout_errs", 32'({err_timeout, err_spurious, err_multi}), 32'(0));
        enable = 1'b0;
        ocnt0  = out_cnt;
        exp_q.push_back(mk(3, 8'h77));
        drive_push(4'b1000, {8'h77, 24'h0});
        repeat (250) @(negedge clk);
        check("timeout_early", 32'(err_timeout), 32'(0));
        repeat (50) @(negedge clk);
        check("timeout_set", 32'(err_timeout), 32'b1000);
        check("no_out_while_disabled", 32'(out_cnt), 32'(ocnt0));
        enable = 1'b1;
        wait_outs(ocnt0 + 1, "timeout_delivered");
        repeat (2) @(negedge clk);
        check("timeout_sticky", 32'(err_timeout), 32'b1000);
        check("scoreboard_drained_a", 32'(exp_q.size()), 32'(0));

        // Spurious grant on idle channel, then a multi-bit grant.
        do_reset();
        enable    = 1'b0;
        manual    = 1'b1;
        @(negedge clk);
        man_grant = 4'b0001;
        @(negedge clk);
        man_grant = '0;
        check("spurious_idle", 32'(err_spurious), 32'(1));
        check("multi_after_single", 32'(err_multi), 32'(0));
        ocnt0 = out_cnt;
        base2 = req_cnt[2];
        exp_q.push_back(mk(1, 8'h31));
        drive_push(4'b0110, {8'h00, 8'h32, 8'h31, 8'h00});
        @(negedge clk);
        @(negedge clk);
        check("multi_req_k1", 32'(req), 32'b0110);
        @(negedge clk);
        man_grant = 4'b0110;
        @(negedge clk);
        man_grant = '0;
        check("multi_out_valid", 32'(out_valid), 32'(1));
        check("multi_flag", 32'(err_multi), 32'(1));
        repeat (5) @(negedge clk);
        check("ch2_still_waiting", 32'(out_cnt), 32'(ocnt0 + 1));
        check("ch2_no_rereq", 32'(req_cnt[2] - base2), 32'(1));
        exp_q.push_back(mk(2, 8'h32));
        man_grant = 4'b0100;
        @(negedge clk);
        man_grant = '0;
        check("ch2_serviced", 32'(out_valid), 32'(1));
        manual = 1'b0;
        enable = 1'b1;

        // Reset while req[0] is high discards the payload.
        do_reset();
        drive_push(4'b0001, {24'h0, 8'h55});
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_req0", 32'(req), 32'b0001);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_req", 32'(req), 32'(0));
        check("rst_mid_in_ready", 32'(in_ready), 32'(0));
        check("rst_mid_out", 32'({out_valid, out_id, out_data}), 32'(0));
        check("rst_mid_errs", 32'({err_timeout, err_spurious, err_multi}), 32'(0));
        ocnt0 = out_cnt;
        base1 = req_cnt[0];
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_ready_after", 32'(in_ready), 32'hF);
        repeat (10) @(negedge clk);
        check("rst_mid_no_out", 32'(out_cnt), 32'(ocnt0));
        check("rst_mid_no_req", 32'(req_cnt[0]), 32'(base1));
        check("scoreboard_drained_b", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
